arc4_sequencer: RTL and testbench

ARC4_SEQUENCER -- requirements
Module: arc4_sequencer

---
 rtl/arc4_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_arc4_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/arc4_sequencer.sv
// ARC4 top-level sequencer: runs the init, KSA and PRGA engines in turn
// and lends the single-port S-memory to whichever engine owns it.
module arc4_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic        err,
  output logic [1:0]  phase,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  init_wrdata,
  input  logic [7:0]  ksa_wrdata,
  input  logic [7:0]  prga_wrdata,
  input  logic        init_wren,
  input  logic        ksa_wren,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [3:0] {
    IDLE,
    START_I,
    LOW_I,
    HIGH_I,
    START_K,
    LOW_K,
    HIGH_K,
    START_P,
    LOW_P,
    HIGH_P
  } state_t;

  // Fourth consecutive LOW cycle with the engine still idle
  localparam logic [2:0] TMO_LAST = 3'd3;

  state_t      state;
  state_t      state_n;
  logic [2:0]  cnt;
  logic [2:0]  cnt_n;
  logic [23:0] key_n;
  logic        err_n;
  logic        sel_i;
  logic        sel_k;
  logic        sel_p;
  logic        eng_rdy;

  function automatic state_t high_of(
    input state_t s
  );
    case (s)
      LOW_I:   return HIGH_I;
      LOW_K:   return HIGH_K;
      default: return HIGH_P;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      key_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      key_q <= key_n;
      err   <= err_n;
    end
  end

  always_comb begin
    phase = 2'd0;
    unique case (state)
      START_I, LOW_I, HIGH_I: phase = 2'd1;
      START_K, LOW_K, HIGH_K: phase = 2'd2;
      START_P, LOW_P, HIGH_P: phase = 2'd3;
      default:                phase = 2'd0;
    endcase
  end

  assign sel_i = (phase == 2'd1);
  assign sel_k = (phase == 2'd2);
  assign sel_p = (phase == 2'd3);

  // Only the owning engine reaches the memory; no owner means no write
  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    eng_rdy  = 1'b1;
    unique case (1'b1)
      sel_i: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
        eng_rdy  = init_rdy;
      end
      sel_k: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
        eng_rdy  = ksa_rdy;
      end
      sel_p: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
        eng_rdy  = prga_rdy;
      end
      default: eng_rdy = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    key_n   = key_q;
    err_n   = err;
    rdy     = 1'b0;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_n = START_I;
          key_n   = key;
          err_n   = 1'b0;
        end
      end
      START_I: begin
        init_en = 1'b1;
        cnt_n   = '0;
        state_n = LOW_I;
      end
      START_K: begin
        ksa_en  = 1'b1;
        cnt_n   = '0;
        state_n = LOW_K;
      end
      START_P: begin
        prga_en = 1'b1;
        cnt_n   = '0;
        state_n = LOW_P;
      end
      // Engine must show busy within four samples or the run aborts
      LOW_I, LOW_K, LOW_P: begin
        if (!eng_rdy) begin
          state_n = high_of(state);
        end else if (cnt == TMO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      HIGH_I: begin
        if (eng_rdy) state_n = START_K;
      end
      HIGH_K: begin
        if (eng_rdy) state_n = START_P;
      end
      HIGH_P: begin
        if (eng_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_sequencer.sv
// Bench for arc4_sequencer: engine models with tunable busy windows and
// a cycle-timeline reference built from the handshake rules.
module tb_arc4_sequencer;

  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = '0;
  logic        rdy;
  logic [23:0] key_q;
  logic        err;
  logic [1:0]  phase;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr = '0, ksa_addr = '0, prga_addr = '0;
  logic [7:0]  init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
  logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  int i_l = 1, i_d = 2, k_l = 1, k_d = 2, p_l = 1, p_d = 2;
  int i_age = 0, k_age = 0, p_age = 0;

  int e_ai = BIG, e_ak = BIG, e_ap = BIG, e_end = BIG;
  logic        e_to = 1'b0, e_rs = 1'b0;
  logic        err_prev = 1'b0;
  logic [23:0] kq_prev = '0;

  arc4_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .key(key), .key_q(key_q), .err(err), .phase(phase),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata),
    .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine busy for cycles [en+l, en+l+d-1]; l=0 drops with the en pulse
  always @(posedge clk) begin
    if (init_en) i_age <= 1;
    else if (i_age > 0 && i_age < 100000) i_age <= i_age + 1;
    if (ksa_en) k_age <= 1;
    else if (k_age > 0 && k_age < 100000) k_age <= k_age + 1;
    if (prga_en) p_age <= 1;
    else if (p_age > 0 && p_age < 100000) p_age <= p_age + 1;
  end

  function automatic logic busy(input logic e, input int age,
                                input int l, input int d);
    return (e && l == 0) || (age > 0 && age >= l && age <= l + d - 1);
  endfunction

  assign init_rdy = !busy(init_en, i_age, i_l, i_d);
  assign ksa_rdy  = !busy(ksa_en, k_age, k_l, k_d);
  assign prga_rdy = !busy(prga_en, p_age, p_l, p_d);

  initial begin
    #(50_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle(input int c, input logic [23:0] k);
    logic [1:0]  ph;
    logic [2:0]  ens;
    logic        xr, xe;
    logic [23:0] xk;
    logic [16:0] sp;
    if (c < e_ai || c >= e_end) ph = 2'd0;
    else if (c >= e_ap) ph = 2'd3;
    else if (c >= e_ak) ph = 2'd2;
    else ph = 2'd1;
    ens = {c == e_ai && c < e_end, c == e_ak && c < e_end,
           c == e_ap && c < e_end};
    xr = (c < e_ai) || (c >= e_end);
    xe = (c < e_ai) ? err_prev : (c >= e_end) ? e_to : 1'b0;
    xk = (c < e_ai) ? kq_prev : (e_rs && c >= e_end) ? 24'h0 : k;
    case (ph)
      2'd1:    sp = {init_addr, init_wrdata, init_wren};
      2'd2:    sp = {ksa_addr, ksa_wrdata, ksa_wren};
      2'd3:    sp = {prga_addr, prga_wrdata, prga_wren};
      default: sp = '0;
    endcase
    chk("phase", 32'(phase), 32'(ph));
    chk("en_vec", 32'({init_en, ksa_en, prga_en}), 32'(ens));
    chk("rdy", 32'(rdy), 32'(xr));
    chk("err", 32'(err), 32'(xe));
    chk("key_q", 32'(key_q), 32'(xk));
    chk("s_port", 32'({s_addr, s_wrdata, s_wren}), 32'(sp));
  endtask

  task automatic run(input logic [23:0] k, input int li, input int di,
                     input int lk, input int dk, input int lp,
                     input int dp, input int rst_at);
    int c0, r;
    @(negedge clk);
    c0 = cyc;
    i_l = li; i_d = di; k_l = lk; k_d = dk; p_l = lp; p_d = dp;
    e_ai = c0 + 1; e_ak = BIG; e_ap = BIG; e_to = 1'b0; e_rs = 1'b0;
    if (li > 4) begin
      e_end = e_ai + 5; e_to = 1'b1;
    end else begin
      e_ak = e_ai + li + di + 1;
      if (lk > 4) begin
        e_end = e_ak + 5; e_to = 1'b1;
      end else begin
        e_ap = e_ak + lk + dk + 1;
        if (lp > 4) begin
          e_end = e_ap + 5; e_to = 1'b1;
        end else begin
          e_end = e_ap + lp + dp + 1;
        end
      end
    end
    r = BIG;
    if (rst_at >= 0 && e_ak + rst_at + 1 < e_end) begin
      r = e_ak + rst_at; e_end = r + 1; e_rs = 1'b1; e_to = 1'b0;
    end
    for (int c = c0; c <= e_end + 5; c++) begin
      if (c != c0) @(negedge clk);
      check_cycle(cyc, k);
      if (c == e_ak + 1 && c < e_end)
        chk("mux_ksa", 32'({s_addr, s_wrdata, s_wren}),
            32'({8'hA5, 8'h5A, 1'b1}));
      if (c == e_end + 2) chk("mux_idle_wren", 32'(s_wren), 32'(0));
      en = (c == c0) || (c == e_ak + 2);
      key = (c == c0) ? k : (c == e_ak + 2) ? 24'hFFFFFF : 24'($urandom);
      rst_n = !(c == r);
      init_addr = 8'($urandom); init_wrdata = 8'($urandom);
      ksa_addr = 8'($urandom); ksa_wrdata = 8'($urandom);
      prga_addr = 8'($urandom); prga_wrdata = 8'($urandom);
      init_wren = 1'($urandom); ksa_wren = 1'($urandom);
      prga_wren = 1'($urandom);
      if (c == e_ak) begin
        ksa_addr = 8'hA5; ksa_wrdata = 8'h5A; ksa_wren = 1'b1;
        init_addr = 8'h11; init_wrdata = 8'h22; init_wren = 1'b1;
        prga_addr = 8'h33; prga_wrdata = 8'h44; prga_wren = 1'b1;
      end
      if (c == e_end + 1 || c == r) begin
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
      end
    end
    en = 1'b0;
    err_prev = e_to;
    kq_prev = e_rs ? 24'h0 : k;
  endtask

  function automatic int rl();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(5, 7));
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    rst_n = 1'b0;
    init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
    ksa_addr = 8'h77; ksa_wrdata = 8'h66;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'(1));
    chk("rst_phase", 32'(phase), 32'(0));
    chk("rst_en_vec", 32'({init_en, ksa_en, prga_en}), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_key_q", 32'(key_q), 32'(0));
    chk("rst_s_port", 32'({s_addr, s_wrdata, s_wren}), 32'(0));
    rst_n = 1'b1;

    run(24'h00033C, 1, 256, 1, 1024, 1, 100, -1);
    chk("nominal_key_q", 32'(key_q), 32'(24'h00033C));
    run(24'hC0FFEE, 1, 10, 1000, 5, 1, 5, -1);
    chk("timeout_err", 32'(err), 32'(1));
    run(24'($urandom), 0, 12, 2, 9, 3, 7, -1);
    chk("err_cleared", 32'(err), 32'(0));
    run(24'h5A5A5A, 1, 8, 1, 200, 1, 5, 20);
    chk("rst_mid_key_q", 32'(key_q), 32'(0));
    for (int n = 0; n < 12; n++) begin
      run(24'($urandom), rl(), int'($urandom_range(2, 30)),
          rl(), int'($urandom_range(2, 30)),
          rl(), int'($urandom_range(2, 30)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 6)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
